// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived raster totals, the RGB444 pixel type and
// the background ROM read latency used to size the sync/blank alignment pipe.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int ROM_LATENCY = 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with a per-bit reset value; every stage is exposed
// on taps so callers can use intermediate delays as well as the final output.
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH-1:0][WIDTH-1:0] taps,
    output logic [WIDTH-1:0]            dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (srst) q_reg <= RESET_VAL;
                    else      q_reg <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (srst) q_reg <= RESET_VAL;
                    else      q_reg <= g_stage[gi-1].q_reg;
                end
            end
            assign taps[gi] = q_reg;
        end
    endgenerate

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vga_bg_scanner.sv
// VGA raster generator that scans a 4x-scaled, horizontally scrolling 128-wide
// background ROM and drives blank-masked RGB444 plus active-low syncs.
module vga_bg_scanner
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  scroll_x,
    output logic [6:0]  rom_x,
    output logic [6:0]  rom_y,
    output logic        rom_en,
    input  logic [11:0] rom_color,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] hcount_reg, hcount_next;
    logic [9:0] vcount_reg, vcount_next;
    logic [6:0] scroll_q_reg;
    logic       frame_tick_reg;

    logic       active, hsync_raw, vsync_raw, tick_event;
    logic [7:0] rom_x_sum;

    logic [ROM_LATENCY-1:0][2:0] align_taps;
    logic [2:0]                  align_out;
    logic                        active_d1, active_d2, hsync_d2, vsync_d2;

    rgb444_t rgb_reg;
    logic    hsync_reg, vsync_reg;

    always_comb begin
        hcount_next = hcount_reg + 10'd1;
        vcount_next = vcount_reg;
        if (hcount_reg == H_LAST) begin
            hcount_next = '0;
            vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    assign active     = (hcount_reg < H_ACT_END) && (vcount_reg < V_ACT_END);
    assign hsync_raw  = !((hcount_reg >= HS_START) && (hcount_reg < HS_END));
    assign vsync_raw  = !((vcount_reg >= VS_START) && (vcount_reg < VS_END));
    assign tick_event = (hcount_reg == 10'd0) && (vcount_reg == V_ACT_END);

    // Scroll is only picked up at the start of vertical blanking so a frame
    // is always drawn with one offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_q_reg   <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= tick_event;
            if (tick_event) scroll_q_reg <= scroll_x;
        end
    end

    assign rom_x_sum = hcount_reg[9:2] + {1'b0, scroll_q_reg};
    assign rom_x     = rom_x_sum[6:0];
    assign rom_y     = vcount_reg[8:2];

    pipe_delay #(
        .WIDTH     (3),
        .DEPTH     (ROM_LATENCY),
        .RESET_VAL (3'b011)
    ) u_align (
        .clk  (clk),
        .srst (reset),
        .din  ({active, hsync_raw, vsync_raw}),
        .taps (align_taps),
        .dout (align_out)
    );

    assign active_d1 = align_taps[0][2];
    assign active_d2 = align_out[2];
    assign hsync_d2  = align_out[1];
    assign vsync_d2  = align_out[0];

    // The ROM holds its output while disabled, so the enable stays up one
    // cycle past the last active pixel to push it through the second stage.
    // It is also held low during reset while the counters sit at (0,0).
    assign rom_en = !reset && (active || active_d1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg   <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            rgb_reg   <= active_d2 ? rgb444_t'(rom_color) : '0;
            hsync_reg <= hsync_d2;
            vsync_reg <= vsync_d2;
        end
    end

    assign vga_r      = rgb_reg.r;
    assign vga_g      = rgb_reg.g;
    assign vga_b      = rgb_reg.b;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign frame_tick = frame_tick_reg;

endmodule
